// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA pixel stages.
//   H_DISPLAY / V_DISPLAY : visible area of the timing generator
//   rgb_t                 : 2 bits per channel, packed as {r, g, b}
//   PALETTE               : sprite colours indexed by the 3-bit colour index
//   dir_e, axis_t         : per-axis motion direction and one-step result
//   axis_step()           : advance one axis by one frame, clamping at the edges
package vga_pkg;

  localparam int H_DISPLAY = 640;
  localparam int V_DISPLAY = 480;

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
  } rgb_t;

  // Entry 0 is white so a freshly reset sprite is easy to spot.
  localparam logic [5:0] PALETTE [8] = '{
    6'b111111, 6'b110000, 6'b001100, 6'b000011,
    6'b111100, 6'b001111, 6'b110011, 6'b101010
  };

  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_e;

  typedef struct packed {
    logic [9:0] pos;
    dir_e       dir;
    logic       bounced;
  } axis_t;

  // Positions are widened to 11 bits so pos + step can never wrap; a bounce
  // clamps exactly onto the edge rather than overshooting it.
  function automatic axis_t axis_step(input logic [9:0]  pos,
                                      input dir_e        dir,
                                      input logic [10:0] step,
                                      input logic [10:0] limit);
    axis_t       res;
    logic [10:0] wide;
    wide        = {1'b0, pos};
    res.pos     = pos;
    res.dir     = dir;
    res.bounced = 1'b0;
    if (dir == DIR_POS) begin
      if (wide + step >= limit) begin
        res.pos     = limit[9:0];
        res.dir     = DIR_NEG;
        res.bounced = 1'b1;
      end else begin
        res.pos = 10'(wide + step);
      end
    end else begin
      if (wide <= step) begin
        res.pos     = '0;
        res.dir     = DIR_POS;
        res.bounced = 1'b1;
      end else begin
        res.pos = 10'(wide - step);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sprite_motion.sv
// Sprite position state: detects the frame tick on the vsync rising edge and
// moves the sprite once per frame, bouncing off the visible-area edges.
//   clk, reset   : pixel clock, synchronous active-high reset
//   vsync_in     : vsync from the timing generator
//   pause        : 1 freezes motion on a tick
//   x, y         : sprite top-left corner
//   colour_idx   : palette index, advances on every bounce event
//   bounce_count : wrapping count of bounce events
module sprite_motion
  import vga_pkg::*;
#(
  parameter int SPRITE_W = 32,
  parameter int SPRITE_H = 32,
  parameter int X_INIT   = 100,
  parameter int Y_INIT   = 50,
  parameter int SPEED    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync_in,
  input  logic       pause,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic [2:0] colour_idx,
  output logic [7:0] bounce_count
);

  localparam logic [10:0] X_MAX = 11'(H_DISPLAY - SPRITE_W);
  localparam logic [10:0] Y_MAX = 11'(V_DISPLAY - SPRITE_H);
  localparam logic [10:0] STEP  = 11'(SPEED);

  logic  vsync_prev;
  logic  armed;
  logic  tick;
  dir_e  dir_x;
  dir_e  dir_y;
  axis_t next_x;
  axis_t next_y;

  // armed stays low after reset until vsync_in has been seen low, so a vsync
  // held high through reset cannot fake a rising edge on release.
  assign tick   = vsync_in & ~vsync_prev & armed;
  assign next_x = axis_step(x, dir_x, STEP, X_MAX);
  assign next_y = axis_step(y, dir_y, STEP, Y_MAX);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent logic.
  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_prev   <= 1'b0;
      armed        <= 1'b0;
      x            <= 10'(X_INIT);
      y            <= 10'(Y_INIT);
      dir_x        <= DIR_POS;
      dir_y        <= DIR_POS;
      colour_idx   <= '0;
      bounce_count <= '0;
    end else begin
      vsync_prev <= vsync_in;
      if (!vsync_in) armed <= 1'b1;
      if (tick && !pause) begin
        x     <= next_x.pos;
        dir_x <= next_x.dir;
        y     <= next_y.pos;
        dir_y <= next_y.dir;
        // A corner hit bounces both axes on one tick but is a single event.
        if (next_x.bounced || next_y.bounced) begin
          colour_idx   <= colour_idx + 3'd1;
          bounce_count <= bounce_count + 8'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bouncing_sprite_renderer.sv
// Pixel stage after the VGA timing generator: draws a bouncing solid sprite
// over a checkerboard and delays the syncs to stay aligned with the pixels.
//   clk, reset            : pixel clock, synchronous active-high reset
//   hsync_in, vsync_in    : syncs from the timing generator
//   display_on            : visible-area flag
//   hpos, vpos            : current column / row
//   pause                 : 1 freezes sprite motion, rendering continues
//   r, g, b               : 2-bit colour channels, 2 clocks after the inputs
//   hsync_out, vsync_out  : syncs delayed 2 clocks
//   bounce_count          : wrapping count of bounce events
module bouncing_sprite_renderer
  import vga_pkg::*;
#(
  parameter int SPRITE_W = 32,
  parameter int SPRITE_H = 32,
  parameter int X_INIT   = 100,
  parameter int Y_INIT   = 50,
  parameter int SPEED    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       display_on,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       pause,
  output logic [1:0] r,
  output logic [1:0] g,
  output logic [1:0] b,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic [7:0] bounce_count
);

  logic [9:0] x;
  logic [9:0] y;
  logic [2:0] colour_idx;

  sprite_motion #(
    .SPRITE_W (SPRITE_W),
    .SPRITE_H (SPRITE_H),
    .X_INIT   (X_INIT),
    .Y_INIT   (Y_INIT),
    .SPEED    (SPEED)
  ) u_motion (
    .clk          (clk),
    .reset        (reset),
    .vsync_in     (vsync_in),
    .pause        (pause),
    .x            (x),
    .y            (y),
    .colour_idx   (colour_idx),
    .bounce_count (bounce_count)
  );

  // Stage 1: hit test against the current position.
  logic       in_spr;
  logic       in_spr_d1;
  logic       checker_d1;
  logic [2:0] idx_d1;
  logic       display_on_d1;
  logic       hsync_d1;
  logic       vsync_d1;

  // 11-bit compares so x + SPRITE_W near the right edge cannot wrap.
  assign in_spr = ({1'b0, hpos} >= {1'b0, x}) &&
                  ({1'b0, hpos} <  {1'b0, x} + 11'(SPRITE_W)) &&
                  ({1'b0, vpos} >= {1'b0, y}) &&
                  ({1'b0, vpos} <  {1'b0, y} + 11'(SPRITE_H));

  // The colour index is captured with the hit so a pixel always pairs with
  // the colour of the position it was tested against.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_spr_d1     <= 1'b0;
      checker_d1    <= 1'b0;
      idx_d1        <= '0;
      display_on_d1 <= 1'b0;
      hsync_d1      <= 1'b0;
      vsync_d1      <= 1'b0;
    end else begin
      in_spr_d1     <= in_spr;
      checker_d1    <= hpos[5] ^ vpos[5];
      idx_d1        <= colour_idx;
      display_on_d1 <= display_on;
      hsync_d1      <= hsync_in;
      vsync_d1      <= vsync_in;
    end
  end

  // Stage 2: colour select.
  rgb_t pix_next;
  rgb_t pix;

  // NOTE: pix_next gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    pix_next = '0;
    if (display_on_d1) begin
      if (in_spr_d1) begin
        pix_next = rgb_t'(PALETTE[idx_d1]);
      end else begin
        pix_next.b = checker_d1 ? 2'b01 : 2'b00;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pix       <= '0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else begin
      pix       <= pix_next;
      hsync_out <= hsync_d1;
      vsync_out <= vsync_d1;
    end
  end

  assign r = pix.r;
  assign g = pix.g;
  assign b = pix.b;

endmodule
